// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// pc_update_unit : PC register and fetch sequencer (IDLE/FETCH/STALL/HALT)
//                  with saturating retired-instruction and stall counters.
// Revision 1.0
// ============================================================================
module pc_update_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_seq,
  input  logic [31:0]          pc_target,
  input  logic                 jump,
  input  logic                 beq,
  input  logic                 bne,
  input  logic                 zero,
  input  logic                 halt,
  input  logic                 busywait,
  output logic [31:0]          pc,
  output logic                 instr_read,
  output logic                 stalled,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] next_addr;
  logic        take;
  logic        inc_retired;
  logic        inc_stall;

  assign take      = jump | (beq & zero) | (bne & ~zero);
  assign next_addr = (take ? pc_target : pc_seq) & 32'hFFFF_FFFC;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    inc_retired = 1'b0;
    inc_stall   = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH, S_STALL: begin
        // Busywait outranks halt; control inputs are ignored until it falls.
        if (busywait) begin
          state_next = S_STALL;
          inc_stall  = 1'b1;
        end else if (halt) begin
          state_next  = S_HALT;
          inc_retired = 1'b1;
        end else begin
          state_next  = S_FETCH;
          pc_next     = next_addr;
          inc_retired = 1'b1;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= RESET_VECTOR;
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (inc_retired && retired_count != CNT_MAX)
        retired_count <= retired_count + CNT_ONE;
      if (inc_stall && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
    end
  end

  assign instr_read = (state == S_FETCH) || (state == S_STALL);
  assign stalled    = (state == S_STALL);
  assign halted     = (state == S_HALT);

endmodule
`default_nettype wire
